ho_seq_ctrl: RTL and testbench

// Sequencer for the hardware-obfuscation datapath (AES core + Trivium keygen + static/dynamic obfuscation).

---
 rtl/ho_seq_ctrl_pkg.sv | 14 +
 rtl/ho_seq_ctrl_wdog.sv | 18 +
 rtl/ho_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_ho_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ho_seq_ctrl_pkg.sv
// ho_seq_ctrl_pkg: state encoding, error codes and wait-state helper for the sequencer
package ho_seq_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_KLOAD, S_KWAIT, S_RSEED, S_RWAIT, S_DLOAD,
    S_AWAIT, S_KGEN, S_OWAIT, S_DONE, S_ERR
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOKEY   = 2'b10;
  localparam logic [1:0] ERR_EARLY   = 2'b11;
  function automatic logic is_wait(state_t s);
    return s inside {S_KWAIT, S_RWAIT, S_AWAIT, S_KGEN, S_OWAIT};
  endfunction
endpackage

// File: rtl/ho_seq_ctrl_wdog.sv
// ho_seq_ctrl_wdog: wait-state watchdog; expires in the cycle the count would reach TIMEOUT
module ho_seq_ctrl_wdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TO_W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/ho_seq_ctrl.sv
// ho_seq_ctrl: sequences AES key/data loads, Trivium reseed/keystream and obfuscation completion
module ho_seq_ctrl
  import ho_seq_ctrl_pkg::*;
#(
  parameter int TO_W         = 8,
  parameter int TIMEOUT      = 200,
  parameter int CNT_W        = 5,
  parameter int RESEED_EVERY = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             new_key,
  input  logic             clr_err,
  input  logic             aes_kvld,
  input  logic             aes_dvld,
  input  logic             rng_valid,
  input  logic             obf_done,
  output logic             aes_krdy,
  output logic             aes_drdy,
  output logic             aes_en,
  output logic             rng_ready,
  output logic             rng_reseed,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] blk_cnt
);
  state_t state_q, state_d;
  logic key_ok_q, key_ok_d, pend_q, pend_d, expire;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0] err_code_q, err_code_d;
  localparam logic [CNT_W-1:0] BLK_MAX = CNT_W'(RESEED_EVERY);

  ho_seq_ctrl_wdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i(CLK), .rst_i(RST), .clr_i(state_d != state_q),
    .en_i(is_wait(state_q)), .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    key_ok_d   = key_ok_q;
    blk_cnt_d  = blk_cnt_q;
    err_code_d = err_code_q;
    pend_d     = pend_q && (state_q == S_KLOAD || state_q == S_KWAIT);
    case (state_q)
      S_IDLE: begin
        pend_d = new_key && start;
        if (new_key) state_d = S_KLOAD;
        else if (start && !key_ok_q) begin
          state_d    = S_ERR;
          err_code_d = ERR_NOKEY;
        end else if (start) state_d = (blk_cnt_q == BLK_MAX) ? S_RSEED : S_DLOAD;
      end
      S_KLOAD: state_d = S_KWAIT;
      S_KWAIT: if (aes_kvld) begin
        key_ok_d  = 1'b1;
        blk_cnt_d = '0;
        state_d   = pend_q ? S_DLOAD : S_IDLE;
      end
      S_RSEED: state_d = S_RWAIT;
      S_RWAIT: if (rng_valid) begin
        blk_cnt_d = '0;
        state_d   = S_DLOAD;
      end
      S_DLOAD: state_d = S_AWAIT;
      S_AWAIT: state_d = aes_dvld ? S_KGEN : S_AWAIT;
      S_KGEN: begin
        if (rng_valid) state_d = S_OWAIT;
        else if (obf_done) begin
          state_d    = S_ERR;
          err_code_d = ERR_EARLY;
        end
      end
      S_OWAIT: state_d = obf_done ? S_DONE : S_OWAIT;
      S_DONE: begin
        blk_cnt_d = (blk_cnt_q == BLK_MAX) ? blk_cnt_q : blk_cnt_q + 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: if (clr_err) begin
        state_d    = S_IDLE;
        err_code_d = ERR_NONE;
      end
      default: state_d = S_IDLE;
    endcase
    // a completion input in the expiry cycle has already moved the state, so it wins
    if (is_wait(state_q) && state_d == state_q && expire) begin
      state_d    = S_ERR;
      err_code_d = ERR_TIMEOUT;
      key_ok_d   = key_ok_q && (state_q != S_KWAIT);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      key_ok_q   <= 1'b0;
      pend_q     <= 1'b0;
      blk_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      key_ok_q   <= key_ok_d;
      pend_q     <= pend_d;
      blk_cnt_q  <= blk_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign aes_krdy   = state_q == S_KLOAD;
  assign aes_drdy   = state_q == S_DLOAD;
  assign rng_reseed = state_q == S_RSEED;
  assign rng_ready  = state_q == S_KGEN;
  assign done       = state_q == S_DONE;
  assign err        = state_q == S_ERR;
  assign busy       = state_q != S_IDLE;
  assign aes_en     = state_q != S_ERR;
  assign err_code   = err_code_q;
  assign blk_cnt    = blk_cnt_q;
endmodule

// File: tb/tb_ho_seq_ctrl.sv
// tb_ho_seq_ctrl: vector table, hand-written corner sequences and randomized blocks
module tb_ho_seq_ctrl;
  localparam int RE = 2;
  localparam int TO = 20;
  localparam logic [6:0] I_NK = 7'b1000000, I_ST = 7'b0100000, I_CE = 7'b0010000,
                         I_KV = 7'b0001000, I_DV = 7'b0000100, I_RV = 7'b0000010, I_OD = 7'b0000001;
  // expected strobe word order: krdy, drdy, rng_ready, reseed, done, busy, err, aes_en
  localparam logic [7:0] S_ID = 8'b0000_0001, S_KL = 8'b1000_0101, S_WT = 8'b0000_0101,
                         S_DL = 8'b0100_0101, S_KG = 8'b0010_0101, S_DN = 8'b0000_1101,
                         S_ER = 8'b0000_0110;
  logic CLK = 0, RST = 1;
  logic start = 0, new_key = 0, clr_err = 0, aes_kvld = 0, aes_dvld = 0, rng_valid = 0, obf_done = 0;
  logic aes_krdy, aes_drdy, aes_en, rng_ready, rng_reseed, busy, done, err;
  logic [1:0] err_code;
  logic [4:0] blk_cnt;
  int checks = 0, failures = 0;
  int n_drdy = 0, n_done = 0, n_rsd = 0, n_rrdy = 0;
  bit m_key = 0;
  int m_blk = 0;

  typedef struct {
    logic [6:0] ins;
    logic [7:0] s;
    logic [1:0] c;
    logic [4:0] b;
    string      nm;
  } vec_t;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  ho_seq_ctrl #(.TO_W(8), .TIMEOUT(TO), .CNT_W(5), .RESEED_EVERY(RE)) dut (
    .CLK(CLK), .RST(RST), .start(start), .new_key(new_key), .clr_err(clr_err),
    .aes_kvld(aes_kvld), .aes_dvld(aes_dvld), .rng_valid(rng_valid), .obf_done(obf_done),
    .aes_krdy(aes_krdy), .aes_drdy(aes_drdy), .aes_en(aes_en), .rng_ready(rng_ready),
    .rng_reseed(rng_reseed), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .blk_cnt(blk_cnt)
  );

  always @(negedge CLK) begin
    n_drdy += int'(aes_drdy);
    n_done += int'(done);
    n_rsd  += int'(rng_reseed);
    n_rrdy += int'(rng_ready);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(string nm, logic [7:0] s, logic [1:0] c, logic [4:0] b);
    chk(nm, 32'({aes_krdy, aes_drdy, rng_ready, rng_reseed, done, busy, err, aes_en, err_code, blk_cnt}),
        32'({s, c, b}));
  endtask

  function automatic void add(logic [6:0] ins, logic [7:0] s, logic [1:0] c, logic [4:0] b, string nm);
    vec_t v;
    v.ins = ins; v.s = s; v.c = c; v.b = b; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic clear_err();
    clr_err = 1; step(); clr_err = 0;
    chk_state("clr_err", S_ID, 2'd0, 5'(m_blk));
  endtask

  task automatic load_key(int d);
    new_key = 1; step(); new_key = 0;
    chk("krdy", 32'(aes_krdy), 1);
    repeat (d) step();
    aes_kvld = 1; step(); aes_kvld = 0;
    m_key = 1;
    m_blk = 0;
    chk_state("key_loaded", S_ID, 2'd0, 5'd0);
  endtask

  task automatic do_block(int d_rs, int d_dv, int d_rv, int d_od);
    int c_drdy, c_done, c_rsd, c_rrdy;
    bit rs;
    c_drdy = n_drdy; c_done = n_done; c_rsd = n_rsd; c_rrdy = n_rrdy;
    rs = (m_blk == RE);
    start = 1; step(); start = 0;
    if (rs) begin
      chk("reseed_strobe", 32'(rng_reseed), 1);
      repeat (d_rs) step();
      rng_valid = 1; step(); rng_valid = 0;
      m_blk = 0;
    end
    chk("drdy", 32'(aes_drdy), 1);
    // unrelated requests and stray completions while busy must be ignored
    repeat (d_dv) begin
      {start, new_key, aes_kvld, rng_valid, obf_done} = 5'($urandom);
      step();
    end
    {start, new_key, aes_kvld, rng_valid, obf_done} = '0;
    aes_dvld = 1; step(); aes_dvld = 0;
    chk("kgen_rng_ready", 32'(rng_ready), 1);
    repeat (d_rv) step();
    chk("kgen_hold", 32'(rng_ready), 1);
    rng_valid = 1; step(); rng_valid = 0;
    chk("owait_no_ready", 32'(rng_ready), 0);
    repeat (d_od) step();
    obf_done = 1; step(); obf_done = 0;
    chk("done_pulse", 32'(done), 1);
    step();
    m_blk = (m_blk + 1 > RE) ? RE : m_blk + 1;
    chk_state("block_end", S_ID, 2'd0, 5'(m_blk));
    chk("drdy_count", 32'(n_drdy - c_drdy), 1);
    chk("done_count", 32'(n_done - c_done), 1);
    chk("reseed_count", 32'(n_rsd - c_rsd), 32'(rs));
    chk("rng_ready_cycles", 32'(n_rrdy - c_rrdy), 32'(d_rv + 1));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add(I_ST, S_ER, 2'd2, 5'd0, "nokey_start");
    add(7'd0, S_ER, 2'd2, 5'd0, "err_hold");
    add(I_CE, S_ID, 2'd0, 5'd0, "clr_err_tbl");
    add(I_ST, S_ER, 2'd2, 5'd0, "nokey_again");
    add(I_CE, S_ID, 2'd0, 5'd0, "clr_err_tbl2");
    add(I_NK, S_KL, 2'd0, 5'd0, "krdy_pulse");
    for (int i = 0; i < 9; i++) add(7'd0, S_WT, 2'd0, 5'd0, "kwait");
    add(I_KV, S_ID, 2'd0, 5'd0, "key_done");
    add(I_ST, S_DL, 2'd0, 5'd0, "drdy_t1");
    for (int i = 0; i < 14; i++) add(7'd0, S_WT, 2'd0, 5'd0, "await");
    add(I_DV, S_KG, 2'd0, 5'd0, "kgen");
    add(7'd0, S_KG, 2'd0, 5'd0, "kgen_hold_tbl");
    add(I_RV, S_WT, 2'd0, 5'd0, "owait");
    add(7'd0, S_WT, 2'd0, 5'd0, "owait_hold");
    add(7'd0, S_WT, 2'd0, 5'd0, "owait_hold");
    add(I_OD, S_DN, 2'd0, 5'd0, "done_tbl");
    add(7'd0, S_ID, 2'd0, 5'd1, "blk1");

    step(); step();
    chk_state("reset", S_ID, 2'd0, 5'd0);
    RST = 0;
    foreach (tbl[i]) begin
      {new_key, start, clr_err, aes_kvld, aes_dvld, rng_valid, obf_done} = tbl[i].ins;
      step();
      chk_state(tbl[i].nm, tbl[i].s, tbl[i].c, tbl[i].b);
    end
    {new_key, start, clr_err, aes_kvld, aes_dvld, rng_valid, obf_done} = '0;
    m_key = 1;
    m_blk = 1;

    do_block(1, 3, 0, 0);
    do_block(2, 2, 1, 1);
    chk("third_block_blk", 32'(blk_cnt), 1);

    start = 1; step(); start = 0;
    chk("to_drdy", 32'(aes_drdy), 1);
    step();
    repeat (TO - 1) step();
    chk_state("await_before_to", S_WT, 2'd0, 5'(m_blk));
    step();
    chk_state("await_timeout", S_ER, 2'd1, 5'(m_blk));
    clear_err();

    start = 1; step(); start = 0;
    step();
    repeat (TO - 1) step();
    aes_dvld = 1; step(); aes_dvld = 0;
    chk_state("dvld_wins", S_KG, 2'd0, 5'(m_blk));
    rng_valid = 1; step(); rng_valid = 0;
    obf_done = 1; step(); obf_done = 0;
    chk("dvld_wins_done", 32'(done), 1);
    step();
    m_blk = m_blk + 1;
    chk_state("dvld_wins_end", S_ID, 2'd0, 5'(m_blk));

    new_key = 1; step(); new_key = 0;
    step();
    repeat (TO - 1) step();
    chk_state("kwait_before_to", S_WT, 2'd0, 5'(m_blk));
    step();
    chk_state("kwait_timeout", S_ER, 2'd1, 5'(m_blk));
    clear_err();
    start = 1; step(); start = 0;
    chk_state("key_cleared", S_ER, 2'd2, 5'(m_blk));
    clear_err();

    load_key(3);
    start = 1; step(); start = 0;
    step();
    aes_dvld = 1; step(); aes_dvld = 0;
    obf_done = 1; step(); obf_done = 0;
    chk_state("early_obf", S_ER, 2'd3, 5'd0);
    clear_err();

    new_key = 1; start = 1; step(); new_key = 0; start = 0;
    chk_state("pend_krdy", S_KL, 2'd0, 5'd0);
    step();
    aes_kvld = 1; step(); aes_kvld = 0;
    chk_state("pend_drdy", S_DL, 2'd0, 5'd0);
    step();
    chk_state("pend_await", S_WT, 2'd0, 5'd0);
    RST = 1; step(); RST = 0;
    chk_state("rst_mid", S_ID, 2'd0, 5'd0);
    m_key = 0;
    m_blk = 0;
    start = 1; step(); start = 0;
    chk_state("rst_clears_key", S_ER, 2'd2, 5'd0);
    clear_err();

    for (int i = 0; i < 40; i++) begin
      if (!m_key || $urandom_range(0, 4) == 0) load_key(int'($urandom_range(1, 6)));
      else do_block(int'($urandom_range(1, 6)), int'($urandom_range(1, 15)),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
